// File: rtl/mini_src_ctrl_pkg.sv
// Shared definitions for the Mini SRC control sequencer: opcodes, FSM states,
// and the packed control word handed from the decoder to the datapath pins.
package mini_src_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] MEM_TIMEOUT_DEF = 4'd15;

  typedef enum logic [3:0] {
    ST_RST, ST_F0, ST_F1, ST_F2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7,
    ST_HALT, ST_WAIT_STEP
  } state_e;

  typedef struct packed {
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rin;
    logic       rout;
    logic       ba_out;
    logic       c_out;
    logic       pc_out;
    logic       inc_pc;
    logic       pc_in;
    logic       mar_in;
    logic       mdr_in;
    logic       mdr_out;
    logic       read;
    logic       write;
    logic       y_in;
    logic       z_in;
    logic       zlow_out;
    logic       ir_in_en;
    logic       con_in;
    logic [4:0] alu_op;
    logic       run;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_rtype(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_itype(input logic [4:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic is_mem_addr(input logic [4:0] op);
    return (op == OP_LDI) || (op == OP_LD) || (op == OP_ST);
  endfunction

  function automatic logic is_known(input logic [4:0] op);
    return is_rtype(op) || is_itype(op) || is_mem_addr(op) ||
           (op == OP_BR) || (op == OP_NOP) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational Moore decode: (state, opcode, con_ff) -> full control word.
module ctrl_decode
  import mini_src_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [4:0] opcode,
  input  logic       con_ff,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl     = '0;
    ctrl.run = (state != ST_RST) && (state != ST_HALT) && (state != ST_WAIT_STEP);
    unique case (state)
      ST_F0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.z_in   = 1'b1;
      end
      ST_F1: begin
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = 1'b1;
        ctrl.read     = 1'b1;
        ctrl.mdr_in   = 1'b1;
      end
      ST_F2: begin
        ctrl.mdr_out  = 1'b1;
        ctrl.ir_in_en = 1'b1;
      end
      ST_T3: begin
        if (is_rtype(opcode) || is_itype(opcode)) begin
          ctrl.grb  = 1'b1;
          ctrl.rout = 1'b1;
          ctrl.y_in = 1'b1;
        end else if (is_mem_addr(opcode)) begin
          ctrl.grb    = 1'b1;
          ctrl.ba_out = 1'b1;
          ctrl.y_in   = 1'b1;
        end else if (opcode == OP_BR) begin
          ctrl.gra    = 1'b1;
          ctrl.rout   = 1'b1;
          ctrl.con_in = 1'b1;
        end else if (!is_known(opcode)) begin
          ctrl.illegal_op = 1'b1;
        end
      end
      ST_T4: begin
        if (is_rtype(opcode)) begin
          ctrl.grc    = 1'b1;
          ctrl.rout   = 1'b1;
          ctrl.alu_op = opcode;
          ctrl.z_in   = 1'b1;
        end else if (is_itype(opcode)) begin
          ctrl.c_out  = 1'b1;
          ctrl.alu_op = opcode;
          ctrl.z_in   = 1'b1;
        end else if (is_mem_addr(opcode)) begin
          ctrl.c_out  = 1'b1;
          ctrl.alu_op = OP_ADD;
          ctrl.z_in   = 1'b1;
        end else if (opcode == OP_BR) begin
          ctrl.pc_out = 1'b1;
          ctrl.y_in   = 1'b1;
        end
      end
      ST_T5: begin
        if (is_rtype(opcode) || is_itype(opcode) || (opcode == OP_LDI)) begin
          ctrl.zlow_out = 1'b1;
          ctrl.gra      = 1'b1;
          ctrl.rin      = 1'b1;
        end else if ((opcode == OP_LD) || (opcode == OP_ST)) begin
          ctrl.zlow_out = 1'b1;
          ctrl.mar_in   = 1'b1;
        end else if (opcode == OP_BR) begin
          ctrl.c_out  = 1'b1;
          ctrl.alu_op = OP_ADD;
          ctrl.z_in   = 1'b1;
        end
      end
      ST_T6: begin
        if (opcode == OP_LD) begin
          ctrl.read   = 1'b1;
          ctrl.mdr_in = 1'b1;
        end else if (opcode == OP_ST) begin
          // read stays low so the MDR captures the bus, not memory
          ctrl.gra    = 1'b1;
          ctrl.rout   = 1'b1;
          ctrl.mdr_in = 1'b1;
        end else if (opcode == OP_BR) begin
          ctrl.zlow_out = 1'b1;
          ctrl.pc_in    = con_ff;
        end
      end
      ST_T7: begin
        if (opcode == OP_LD) begin
          ctrl.mdr_out = 1'b1;
          ctrl.gra     = 1'b1;
          ctrl.rin     = 1'b1;
        end else if (opcode == OP_ST) begin
          ctrl.write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Mini SRC multi-cycle control unit: fetch F0..F2, execute T3..T7, memory
// wait with timeout. Optional SINGLE_STEP_EN adds a step input and WAIT_STEP.
module control_sequencer
  import mini_src_ctrl_pkg::*;
#(
  parameter logic [3:0] MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] ir_in,
  input  logic        con_ff,
  input  logic        mem_ready,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        rin,
  output logic        rout,
  output logic        ba_out,
  output logic        c_out,
  output logic        pc_out,
  output logic        inc_pc,
  output logic        pc_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        read,
  output logic        write,
  output logic        y_in,
  output logic        z_in,
  output logic        zlow_out,
  output logic        ir_in_en,
  output logic        con_in,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        illegal_op,
  output logic        mem_err,
  output state_e      dbg_state
);

  // Memory handshake: a wait state holds its strobes until a cycle with
  // mem_ready=1 at the rising edge, which completes the access and advances.
  state_e     state_q, state_d, done_state;
  logic [3:0] cnt_q, cnt_d;
  logic       mem_err_q, mem_err_d;
  logic       mem_wait;
  logic [4:0] opcode;
  ctrl_t      ctrl;
  logic       unused_ir;

  assign opcode    = ir_in[31:27];
  assign unused_ir = ^ir_in[26:0];

`ifdef SINGLE_STEP_EN
  logic step_q, step_d, step_rise;
  assign step_d     = step;
  assign step_rise  = step & ~step_q;
  assign done_state = ST_WAIT_STEP;
`else
  assign done_state = ST_F0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_RST;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
`ifdef SINGLE_STEP_EN
      step_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
`ifdef SINGLE_STEP_EN
      step_q    <= step_d;
`endif
    end
  end

  assign mem_wait = (state_q == ST_F1) ||
                    ((state_q == ST_T6) && (opcode == OP_LD)) ||
                    ((state_q == ST_T7) && (opcode == OP_ST));

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    mem_err_d = mem_err_q;
    unique case (state_q)
      ST_RST:  state_d = ST_F0;
      ST_F0:   state_d = ST_F1;
      ST_F1:   if (mem_ready) state_d = ST_F2;
      ST_F2:   state_d = ST_T3;
      ST_T3: begin
        if (opcode == OP_HALT)     state_d = ST_HALT;
        else if (opcode == OP_NOP) state_d = done_state;
        else if (!is_known(opcode)) state_d = ST_F0;
        else                       state_d = ST_T4;
      end
      ST_T4:   state_d = ST_T5;
      ST_T5: begin
        if ((opcode == OP_LD) || (opcode == OP_ST) || (opcode == OP_BR)) state_d = ST_T6;
        else                                                          state_d = done_state;
      end
      ST_T6: begin
        if (opcode == OP_BR)      state_d = done_state;
        else if (opcode == OP_ST) state_d = ST_T7;
        else if (mem_ready)       state_d = ST_T7;
      end
      ST_T7: if (mem_ready) state_d = done_state;
      ST_HALT: state_d = ST_HALT;
      ST_WAIT_STEP: begin
`ifdef SINGLE_STEP_EN
        if (step_rise) state_d = ST_F0;
`else
        state_d = ST_F0;
`endif
      end
      default: state_d = ST_RST;
    endcase

    // Timeout overrides the stay-in-place decision of any wait state.
    if (mem_wait && !mem_ready) begin
      if (cnt_q == (MEM_TIMEOUT - 4'd1)) begin
        state_d   = ST_HALT;
        mem_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  ctrl_decode u_decode (
    .state  (state_q),
    .opcode (opcode),
    .con_ff (con_ff),
    .ctrl   (ctrl)
  );

  assign gra        = ctrl.gra;
  assign grb        = ctrl.grb;
  assign grc        = ctrl.grc;
  assign rin        = ctrl.rin;
  assign rout       = ctrl.rout;
  assign ba_out     = ctrl.ba_out;
  assign c_out      = ctrl.c_out;
  assign pc_out     = ctrl.pc_out;
  assign inc_pc     = ctrl.inc_pc;
  assign pc_in      = ctrl.pc_in;
  assign mar_in     = ctrl.mar_in;
  assign mdr_in     = ctrl.mdr_in;
  assign mdr_out    = ctrl.mdr_out;
  assign read       = ctrl.read;
  assign write      = ctrl.write;
  assign y_in       = ctrl.y_in;
  assign z_in       = ctrl.z_in;
  assign zlow_out   = ctrl.zlow_out;
  assign ir_in_en   = ctrl.ir_in_en;
  assign con_in     = ctrl.con_in;
  assign alu_op     = ctrl.alu_op;
  assign run        = ctrl.run;
  assign illegal_op = ctrl.illegal_op;
  assign mem_err    = mem_err_q;
  assign dbg_state  = state_q;

endmodule
